acc_bank: RTL and testbench

//   Parametrised multi-channel accumulator bank; successor to the 8-bit single accumulator.
//   - Holds CHANNELS independent WIDTH-bit accumulators for ALU temporary storage.
//   - Supports add, subtract, load and clear ops, with a sticky per-channel overflow flag.
//   - Has a multi-cycle clear-all sweep; sits between the ALU result bus and the ALU operand mux.

---
 rtl/acc_pkg.sv | 22 ++
 rtl/acc_lane.sv | 58 +++++
 rtl/acc_bank.sv | 166 ++++++++++++++++
 tb/tb_acc_bank.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accumulator bank: op encodings, FSM states and a
// channel-index width helper.
package acc_pkg;

  typedef enum logic [1:0] {
    ACC_ADD   = 2'b00,
    ACC_SUB   = 2'b01,
    ACC_LOAD  = 2'b10,
    ACC_CLEAR = 2'b11
  } acc_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } acc_state_t;

  // A single-channel bank still needs a 1-bit index port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// Combinational single-channel datapath for the accumulator bank.
// Define SATURATE_EN to clamp ADD/SUB results instead of wrapping.
module acc_lane
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  acc_op_t          op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  logic             ovf,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             ovf_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra MSB is the carry for ADD and the borrow for SUB.
  assign sum  = {1'b0, acc} + {1'b0, data};
  assign diff = {1'b0, acc} - {1'b0, data};

  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    case (op)
      ACC_ADD: begin
`ifdef SATURATE_EN
        acc_nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        acc_nxt = sum[WIDTH-1:0];
`endif
        ovf_nxt = ovf | sum[WIDTH];
      end
      ACC_SUB: begin
`ifdef SATURATE_EN
        acc_nxt = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
        acc_nxt = diff[WIDTH-1:0];
`endif
        ovf_nxt = ovf | diff[WIDTH];
      end
      ACC_LOAD: begin
        acc_nxt = data;
        ovf_nxt = 1'b0;
      end
      ACC_CLEAR: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      default: begin
        acc_nxt = acc;
        ovf_nxt = ovf;
      end
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// Multi-channel accumulator bank with sticky overflow and a clear-all sweep.
// SATURATE_EN (see acc_lane) selects clamping instead of wrapping arithmetic.
//
// state    | meaning
// ST_IDLE  | accepting ops, in_ready = 1
// ST_SWEEP | clearing channel idx each cycle, in_ready = 0, busy = 1
module acc_bank
  import acc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_all,
  output logic             busy,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] rd_data
);

  acc_state_t       state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic [WIDTH-1:0] acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             ch_ok;
  logic             accept;
  logic [WIDTH-1:0] lane_acc_in, lane_acc_out;
  logic             lane_ovf_in, lane_ovf_out;

  // With a power-of-two channel count every index is valid.
  if ((1 << CH_W) == CHANNELS) begin : g_full_range
    assign ch_ok = 1'b1;
  end else begin : g_part_range
    assign ch_ok = (in_ch < CH_W'(CHANNELS));
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_SWEEP);
  assign accept   = in_valid & in_ready;

  always_comb begin
    lane_acc_in = '0;
    lane_ovf_in = 1'b0;
    rd_data     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        lane_acc_in = acc_q[i];
        lane_ovf_in = ovf_q[i];
      end
      if (rd_ch == CH_W'(i)) begin
        rd_data = acc_q[i];
      end
    end
  end

  acc_lane #(
    .WIDTH (WIDTH)
  ) u_lane (
    .op      (acc_op_t'(in_op)),
    .acc     (lane_acc_in),
    .data    (in_data),
    .ovf     (lane_ovf_in),
    .acc_nxt (lane_acc_out),
    .ovf_nxt (lane_ovf_out)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && ch_ok) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) begin
              acc_d[i] = lane_acc_out;
              ovf_d[i] = lane_ovf_out;
            end
          end
          out_valid_d = 1'b1;
          out_ch_d    = in_ch;
          out_data_d  = lane_acc_out;
          out_ovf_d   = lane_ovf_out;
        end
        // A same-cycle op has already been applied above; the sweep follows.
        if (clear_all) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx_q == CH_W'(i)) begin
            acc_d[i] = '0;
            ovf_d[i] = 1'b0;
          end
        end
        if (idx_q == CH_W'(CHANNELS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank: a numeric reference model predicts each
// reported result; a negedge monitor pops and compares whenever out_valid is seen.
module tb_acc_bank;
  import acc_pkg::*;

  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #10 clock = ~clock;

  logic          in_valid = 1'b0, clear_all = 1'b0;
  logic [1:0]    in_op = '0, in_ch = '0, rd_ch = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, busy, out_valid, out_ovf;
  logic [1:0]    out_ch;
  logic [W-1:0]  out_data, rd_data;

  acc_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ch(in_ch), .in_data(in_data), .clear_all(clear_all),
    .busy(busy), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .out_ovf(out_ovf), .rd_ch(rd_ch), .rd_data(rd_data)
  );

  // Five-channel build to reach channel indices beyond the bank size.
  logic          v5_valid = 1'b0, v5_clr = 1'b0;
  logic [1:0]    v5_op = '0;
  logic [2:0]    v5_ch = '0, v5_rd_ch = '0, v5_out_ch;
  logic [W-1:0]  v5_data = '0, v5_out_data, v5_rd_data;
  logic          v5_ready, v5_busy, v5_out_valid, v5_out_ovf;

  acc_bank #(.WIDTH(W), .CHANNELS(5)) dut5 (
    .clock(clock), .reset(reset), .in_valid(v5_valid), .in_ready(v5_ready),
    .in_op(v5_op), .in_ch(v5_ch), .in_data(v5_data), .clear_all(v5_clr),
    .busy(v5_busy), .out_valid(v5_out_valid), .out_ch(v5_out_ch), .out_data(v5_out_data),
    .out_ovf(v5_out_ovf), .rd_ch(v5_rd_ch), .rd_data(v5_rd_data)
  );

  typedef struct {
    int ch;
    int data;
    int ovf;
  } exp_t;

  int   m_acc [CH];
  int   m_ovf [CH];
  int   sweep_left = 0;
  exp_t q [$];
  exp_t last = '{0, 0, 0};
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 0;
    end
    sweep_left = 0;
    last = '{0, 0, 0};
  endfunction

  function automatic void model_op(input int op, input int ch, input int data, output exp_t e);
    int s;
    case (op)
      0: begin
        s = m_acc[ch] + data;
        if (s > MAXV) begin
          m_ovf[ch] = 1;
`ifdef SATURATE_EN
          s = MAXV;
`else
          s = s - (MAXV + 1);
`endif
        end
        m_acc[ch] = s;
      end
      1: begin
        s = m_acc[ch] - data;
        if (s < 0) begin
          m_ovf[ch] = 1;
`ifdef SATURATE_EN
          s = 0;
`else
          s = s + (MAXV + 1);
`endif
        end
        m_acc[ch] = s;
      end
      2: begin
        m_acc[ch] = data;
        m_ovf[ch] = 0;
      end
      default: begin
        m_acc[ch] = 0;
        m_ovf[ch] = 0;
      end
    endcase
    e = '{ch, m_acc[ch], m_ovf[ch]};
  endfunction

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input bit v, input int op, input int ch, input int data, input bit clr);
    exp_t e;
    bit   rdy;
    bit   start;
    start     = 1'b0;
    rdy       = (sweep_left == 0);
    in_valid  = v;
    in_op     = op[1:0];
    in_ch     = ch[1:0];
    in_data   = data[W-1:0];
    clear_all = clr;
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("busy", int'(busy), int'(!rdy));
    if (rdy) begin
      if (v) begin
        model_op(op, ch, data, e);
        q.push_back(e);
      end
      if (clr) begin
        for (int c = 0; c < CH; c++) begin
          m_acc[c] = 0;
          m_ovf[c] = 0;
        end
        start = 1'b1;
      end
    end else begin
      sweep_left--;
    end
    if (start) sweep_left = CH;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    clear_all = 1'b0;
  endtask

  task automatic chk_rd();
    for (int c = 0; c < CH; c++) begin
      rd_ch = c[1:0];
      #1;
      chk("rd_data", int'(rd_data), m_acc[c]);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", int'(out_valid), 0);
        end else begin
          e = q.pop_front();
          chk("out_ch", int'(out_ch), e.ch);
          chk("out_data", int'(out_data), e.data);
          chk("out_ovf", int'(out_ovf), e.ovf);
          last = e;
        end
      end else begin
        chk("hold_out_ch", int'(out_ch), last.ch);
        chk("hold_out_data", int'(out_data), last.data);
        chk("hold_out_ovf", int'(out_ovf), last.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk_rd();
    reset = 1'b1;

    // Back-to-back adds on one channel
    cyc(1, 0, 0, 'hB2, 0);
    cyc(1, 0, 0, 'h02, 0);
    cyc(1, 0, 0, 'h0F, 0);

    // Overflow is sticky until LOAD
    cyc(1, 2, 1, 'hF0, 0);
    cyc(1, 0, 1, 'h20, 0);
    cyc(1, 2, 1, 'h05, 0);

    // Borrow from a cleared channel
    cyc(1, 3, 2, 0, 0);
    cyc(1, 1, 2, 'h01, 0);
    chk_rd();

    // Clear-all sweep with a same-cycle op; ops offered during sweep are refused
    cyc(1, 0, 2, 'h03, 0);
    cyc(1, 0, 3, 'h07, 0);
    chk_rd();
    cyc(1, 0, 3, 'h01, 1);
    for (int i = 0; i < CH; i++) cyc(1, 0, i, 'h05, 0);
    chk_rd();
    for (int c = 0; c < CH; c++) cyc(1, 0, c, 0, 0);

    // Reset in the middle of a sweep
    cyc(1, 2, 0, 'h44, 0);
    cyc(1, 2, 1, 'h55, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    chk("mid_rst_pending", q.size(), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk_rd();

    // Five consecutive increments
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 'h01, 0);

    // Out-of-range channels on the five-channel build
    v5_valid = 1'b1; v5_op = 2'b10; v5_ch = 3'd4; v5_data = 8'h33;
    @(posedge clock); #1;
    chk("d5_load_valid", int'(v5_out_valid), 1);
    chk("d5_load_data", int'(v5_out_data), 'h33);
    v5_op = 2'b00; v5_ch = 3'd4; v5_data = 8'h01;
    @(posedge clock); #1;
    chk("d5_add_data", int'(v5_out_data), 'h34);
    for (int c = 5; c < 8; c++) begin
      v5_op = 2'b10; v5_ch = c[2:0]; v5_data = 8'hAA;
      @(posedge clock); #1;
      chk("d5_bad_ch_valid", int'(v5_out_valid), 0);
      chk("d5_bad_ch_hold", int'(v5_out_data), 'h34);
      chk("d5_bad_ch_ready", int'(v5_ready), 1);
    end
    v5_valid = 1'b0;
    v5_rd_ch = 3'd4; #1;
    chk("d5_rd4", int'(v5_rd_data), 'h34);
    for (int c = 5; c < 8; c++) begin
      v5_rd_ch = c[2:0]; #1;
      chk("d5_rd_oob", int'(v5_rd_data), 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, CH - 1)),
          int'($urandom_range(0, MAXV)), $urandom_range(0, 19) == 0);
      if ((n % 50) == 0 && sweep_left == 0) chk_rd();
    end
    while (sweep_left != 0) cyc(0, 0, 0, 0, 0);
    chk_rd();
    @(posedge clock);
    #1;
    chk("pending_results", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
